// File: rtl/l2_dc_responder_pkg.sv
// Shared constants, FSM encoding and latched-request record for the L2 dcache responder.
package l2_dc_responder_pkg;
  localparam int ADDR_W = 28;
  localparam int BLK_W  = 128;
  localparam int WORD_W = 32;
  localparam int NWORDS = BLK_W / WORD_W;
  localparam int IDX_W  = 8;
  localparam int TAG_W  = ADDR_W - IDX_W + 1;
  localparam logic TAG_VLD = 1'b1;

  typedef enum logic [1:0] {
    L2R_IDLE   = 2'd0,
    L2R_WB     = 2'd1,
    L2R_FILL   = 2'd2,
    L2R_REFILL = 2'd3
  } l2r_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wb_addr;
    logic [BLK_W-1:0]  wb_data;
    logic              way;
    logic [1:0]        thread;
    logic              rw;
    logic [WORD_W-1:0] wd;
    logic [1:0]        offset;
  } l2r_req_t;
endpackage

// File: rtl/l2_dc_responder_blk_merge.sv
// Inserts a 32-bit store word into a 128-bit block at the given word offset.
module l2_blk_merge
  import l2_dc_responder_pkg::*;
(
  input  logic [BLK_W-1:0]  blk,
  input  logic [WORD_W-1:0] wd,
  input  logic [1:0]        offset,
  input  logic              en,
  output logic [BLK_W-1:0]  merged
);
  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    assign merged[w*WORD_W +: WORD_W] = (en && offset == 2'(w)) ? wd : blk[w*WORD_W +: WORD_W];
  end
endmodule

// File: rtl/l2_dc_responder.sv
// L2-side responder for L1 dcache misses: optional victim write-back, block fill,
// store-word merge, then a one-cycle refill to L1 tagged with the requesting thread.
module l2_dc_responder
  import l2_dc_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              drq,
  input  logic              access_l2_clean,
  input  logic              access_l2_dirty,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [BLK_W-1:0]  data_wd,
  input  logic              dc_choose_way,
  input  logic [1:0]        dc_thread,
  input  logic              dc_rw,
  input  logic [WORD_W-1:0] dc_wd,
  input  logic [1:0]        offset,
  output logic              l2_busy,
  output logic              l2_rdy,
  output logic              thread_rdy,
  output logic [1:0]        l2_thread,
  output logic              dc_block0_we_l2,
  output logic              dc_block1_we_l2,
  output logic [IDX_W-1:0]  dc_index_l2,
  output logic [TAG_W-1:0]  dc_tag_wd_l2,
  output logic [BLK_W-1:0]  data_wd_l2,
  output logic [WORD_W-1:0] dc_wd_l2,
  output logic              dc_rw_l2,
  output logic [1:0]        offset_l2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wd,
  input  logic              mem_ack,
  input  logic [BLK_W-1:0]  mem_rd
);
  l2r_state_e       state, state_nx;
  l2r_req_t         req_q;
  logic [BLK_W-1:0] blk_q, blk_merged;
  logic             accept;

  assign accept = (state == L2R_IDLE) && drq && (access_l2_clean || access_l2_dirty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= L2R_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      L2R_IDLE:   if (accept) state_nx = access_l2_dirty ? L2R_WB : L2R_FILL;
      L2R_WB:     if (mem_ack) state_nx = L2R_FILL;
      L2R_FILL:   if (mem_ack) state_nx = L2R_REFILL;
      L2R_REFILL: state_nx = L2R_IDLE;
      default:    state_nx = L2R_IDLE;
    endcase
  end

  // mem_req follows the next state so it is up in the first WB/FILL cycle and
  // cannot fall until the ack that moves the FSM on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req <= 1'b0;
      req_q   <= '0;
      blk_q   <= '0;
    end else begin
      mem_req <= (state_nx == L2R_WB) || (state_nx == L2R_FILL);
      if (accept)
        req_q <= '{addr: dc_addr, wb_addr: wb_addr, wb_data: data_wd, way: dc_choose_way,
                   thread: dc_thread, rw: dc_rw, wd: dc_wd, offset: offset};
      if (state == L2R_FILL && mem_ack) blk_q <= mem_rd;
    end
  end

  l2_blk_merge u_merge (
    .blk    (blk_q),
    .wd     (req_q.wd),
    .offset (req_q.offset),
    .en     (req_q.rw),
    .merged (blk_merged)
  );

  always_comb begin
    l2_busy         = (state != L2R_IDLE);
    l2_rdy          = 1'b0;
    dc_block0_we_l2 = 1'b0;
    dc_block1_we_l2 = 1'b0;
    dc_tag_wd_l2    = '0;
    data_wd_l2      = '0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wd          = '0;
    unique case (state)
      L2R_WB: begin
        mem_we   = 1'b1;
        mem_addr = req_q.wb_addr;
        mem_wd   = req_q.wb_data;
      end
      L2R_FILL: mem_addr = req_q.addr;
      L2R_REFILL: begin
        l2_rdy          = 1'b1;
        dc_block0_we_l2 = ~req_q.way;
        dc_block1_we_l2 = req_q.way;
        dc_tag_wd_l2    = {TAG_VLD, req_q.addr[ADDR_W-1:IDX_W]};
        data_wd_l2      = blk_merged;
      end
      default: ;
    endcase
  end

  assign thread_rdy  = l2_rdy;
  assign l2_thread   = req_q.thread;
  assign dc_index_l2 = req_q.addr[IDX_W-1:0];
  assign dc_wd_l2    = req_q.wd;
  assign dc_rw_l2    = req_q.rw;
  assign offset_l2   = req_q.offset;
endmodule
